bus_master_if: RTL and testbench
================================

BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 The block SHALL have these ports, with parameters WORD_ADDR 30 bits, WORD_DATA 32 bits, READ=1, WRITE=0, and all *_n signals active-low:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  reset; synchronous, active-low.
- cpu_req  in  1  core memory-access request, active-high.
- cpu_rw  in  1  READ/WRITE.
- cpu_addr  in  30  word address.
- cpu_wr_data  in  32  write data.
- stall  in  1  core pipeline stall.
- flush  in  1  core pipeline flush.
- cpu_rd_data  out  32  read data returned to the core.
- cpu_busy  out  1  tells the core to hold its request.
- bus_req_n  out  1  bus request to the arbiter.
- bus_grnt_n  in  1  bus grant from the arbiter.
- bus_addr  out  30  bus address.
- bus_as_n  out  1  address strobe.
- bus_rw  out  1  bus read/write.
- bus_wr_data  out  32  bus write data.
- bus_rd_data  in  32  shared slave read data.
- bus_rdy_n  in  1  shared slave ready.
- bus_err  out  1  timeout abort pulse.

Function
REQ-002 The FSM SHALL have exactly the states IDLE, REQ, ACCESS, WAIT and DONE.
REQ-003 In IDLE with cpu_req=1 and flush=0, the block SHALL capture cpu_rw, cpu_addr and cpu_wr_data into internal registers and enter REQ.
REQ-004 In IDLE with flush=1, the request SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-005 In REQ, bus_req_n SHALL be 0; the FSM SHALL enter ACCESS on the first edge that samples bus_grnt_n=0, and SHALL stay in REQ otherwise.
REQ-006 In ACCESS, bus_as_n SHALL be 0 for exactly one cycle, and the FSM SHALL then enter WAIT.
REQ-007 If bus_rdy_n=0 is sampled in ACCESS, the FSM SHALL go directly to DONE.
REQ-008 In WAIT, the FSM SHALL stay until bus_rdy_n=0 is sampled, then enter DONE.
REQ-009 On the edge entering DONE:
- a READ SHALL latch bus_rd_data into rd_buf;
- a WRITE SHALL leave rd_buf unchanged.
REQ-010 bus_req_n SHALL be 0 in REQ, ACCESS and WAIT, and 1 in IDLE and DONE.
REQ-011 bus_addr, bus_rw and bus_wr_data SHALL drive the captured values in ACCESS and WAIT, and SHALL be 0 in all other states.
REQ-012 In DONE, the FSM SHALL return to IDLE when stall=0 and SHALL hold in DONE while stall=1, with no new bus request issued.
REQ-013 cpu_busy SHALL be combinational:
- 1 in IDLE when cpu_req=1 and flush=0;
- 1 in REQ, ACCESS and WAIT;
- 0 otherwise.
REQ-014 cpu_rd_data SHALL equal rd_buf at all times.
REQ-015 With a grant on the first REQ cycle and a slave ready one cycle after the strobe, latency SHALL be: cpu_req sampled at edge 0, REQ at cycle 1, ACCESS at cycle 2, WAIT at cycle 3, DONE at cycle 4 with cpu_busy=0.
REQ-016 flush or a change of cpu_req while in REQ, ACCESS or WAIT SHALL NOT abort the transaction.
REQ-017 If grant is lost while in ACCESS or WAIT, the block SHALL continue the transaction unchanged; the arbiter owns the bus-hold guarantee.

Reset
REQ-018 On any edge with reset=0, the FSM SHALL enter IDLE from any state, including mid-transaction.
REQ-019 On that same edge, the block SHALL set rd_buf=0, the captured registers to 0, bus_req_n=1, bus_as_n=1, bus_addr/bus_rw/bus_wr_data=0, bus_err=0 and the timeout counter to 0.
REQ-020 cpu_busy SHALL follow REQ-013 from the IDLE state.

Configuration
REQ-021 When the macro BUS_MASTER_IF_TIMEOUT_EN is defined, the block SHALL include an 8-bit counter that:
- clears on entering WAIT;
- increments on each cycle in WAIT with bus_rdy_n=1.
REQ-022 When that counter reaches 255, the block SHALL leave WAIT for DONE, set rd_buf=0 on a READ, and pulse bus_err=1 for exactly one cycle.
REQ-023 When the macro is not defined, WAIT SHALL last indefinitely, bus_err SHALL be tied to 0, and the counter logic SHALL be absent.

Verification
REQ-024 Write: cpu_req=1, WRITE, addr 30'h1000_0000, data 32'h1234, grant on the next cycle, rdy_n low one cycle after the strobe -> bus_as_n low for 1 cycle with bus_addr=30'h1000_0000 and bus_wr_data=32'h1234; DONE at cycle 4; cpu_busy=0; cpu_rd_data unchanged.
REQ-025 Read with grant delayed 3 cycles, addr 30'h3F00_0000, slave returns 32'h5678 -> bus_req_n low 6 cycles; cpu_rd_data=32'h5678 in DONE.
REQ-026 Stall held 4 cycles in DONE -> FSM stays in DONE, bus_req_n=1 and cpu_rd_data stable, then returns to IDLE on the first cycle with stall=0.
REQ-027 Flush with cpu_req in IDLE -> no bus_req_n assertion; cpu_busy=0. Flush during WAIT -> the transaction completes normally.
REQ-028 Reset=0 asserted in WAIT -> next edge: IDLE, bus_req_n=1, bus_as_n=1, rd_buf=0.
REQ-029 With BUS_MASTER_IF_TIMEOUT_EN defined and bus_rdy_n held high -> after 256 WAIT cycles: bus_err pulses for 1 cycle and cpu_rd_data=0. Without the macro, the FSM is still in WAIT after 1000 cycles.

Source files
------------

// File: rtl/bus_master_if_if.sv
// Core-side and bus-side signal bundle for bus_master_if.
// master: the view of the bus master block itself.
// slave : the view of whatever sits around it (core, arbiter, slaves).
interface bus_master_if_if #(
   parameter int WORD_ADDR = 30,
   parameter int WORD_DATA = 32
) ();

   // core side
   logic                 cpu_req;
   logic                 cpu_rw;
   logic [WORD_ADDR-1:0] cpu_addr;
   logic [WORD_DATA-1:0] cpu_wr_data;
   logic                 stall;
   logic                 flush;
   logic [WORD_DATA-1:0] cpu_rd_data;
   logic                 cpu_busy;

   // bus side
   logic                 bus_req_n;
   logic                 bus_grnt_n;
   logic [WORD_ADDR-1:0] bus_addr;
   logic                 bus_as_n;
   logic                 bus_rw;
   logic [WORD_DATA-1:0] bus_wr_data;
   logic [WORD_DATA-1:0] bus_rd_data;
   logic                 bus_rdy_n;
   logic                 bus_err;

   modport master (
      input  cpu_req, cpu_rw, cpu_addr, cpu_wr_data, stall, flush,
      input  bus_grnt_n, bus_rd_data, bus_rdy_n,
      output cpu_rd_data, cpu_busy,
      output bus_req_n, bus_addr, bus_as_n, bus_rw, bus_wr_data, bus_err
   );

   modport slave (
      output cpu_req, cpu_rw, cpu_addr, cpu_wr_data, stall, flush,
      output bus_grnt_n, bus_rd_data, bus_rdy_n,
      input  cpu_rd_data, cpu_busy,
      input  bus_req_n, bus_addr, bus_as_n, bus_rw, bus_wr_data, bus_err
   );

endinterface

// File: rtl/bus_master_if.sv
// Single-transaction bus master: takes one core access, arbitrates for the
// bus, issues a one-cycle address strobe and waits for the slave's ready.
//
// Optional feature: define BUS_MASTER_IF_TIMEOUT_EN to add an 8-bit WAIT
// timeout that aborts the access after 256 unready cycles and pulses bus_err.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction; capture a request unless flushed
// REQ    | bus_req_n asserted, waiting for grant
// ACCESS | address strobe cycle; ready here finishes immediately
// WAIT   | holding address, waiting for slave ready (or timeout)
// DONE   | transaction finished, read data valid; held while stalled
module bus_master_if #(
   parameter int WORD_ADDR = 30,
   parameter int WORD_DATA = 32
) (
   input logic              clk,
   input logic              reset,
   bus_master_if_if.master  bus
);

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      ACCESS = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t               state_q;
   state_t               state_d;

   logic                 rw_q;
   logic [WORD_ADDR-1:0] addr_q;
   logic [WORD_DATA-1:0] wr_data_q;
   logic [WORD_DATA-1:0] rd_buf_q;

   logic                 capture;
   logic                 latch_rd;

`ifdef BUS_MASTER_IF_TIMEOUT_EN
   logic [7:0]           tmo_cnt_q;
   logic                 timeout;
   logic                 bus_err_q;
`endif

   // next-state decode and datapath strobes
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      latch_rd = 1'b0;
`ifdef BUS_MASTER_IF_TIMEOUT_EN
      timeout  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.cpu_req && !bus.flush) begin
               state_d = REQ;
               capture = 1'b1;
            end
         end
         REQ: begin
            if (!bus.bus_grnt_n) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // a slave that is already ready skips WAIT entirely
            if (!bus.bus_rdy_n) begin
               state_d  = DONE;
               latch_rd = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // grant and flush are deliberately ignored once the strobe is out
            if (!bus.bus_rdy_n) begin
               state_d  = DONE;
               latch_rd = 1'b1;
            end
`ifdef BUS_MASTER_IF_TIMEOUT_EN
            else if (tmo_cnt_q == 8'hFF) begin
               state_d = DONE;
               timeout = 1'b1;
            end
`endif
         end
         DONE: begin
            if (!bus.stall) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // request capture and read buffer
   always_ff @(posedge clk) begin
      if (!reset) begin
         rw_q      <= WRITE;
         addr_q    <= '0;
         wr_data_q <= '0;
         rd_buf_q  <= '0;
      end else begin
         if (capture) begin
            rw_q      <= bus.cpu_rw;
            addr_q    <= bus.cpu_addr;
            wr_data_q <= bus.cpu_wr_data;
         end
         if (latch_rd && (rw_q == READ)) begin
            rd_buf_q <= bus.bus_rd_data;
         end
`ifdef BUS_MASTER_IF_TIMEOUT_EN
         // an aborted read must not leave stale data visible to the core
         else if (timeout && (rw_q == READ)) begin
            rd_buf_q <= '0;
         end
`endif
      end
   end

`ifdef BUS_MASTER_IF_TIMEOUT_EN
   // WAIT timeout counter: restarts on every entry to WAIT
   always_ff @(posedge clk) begin
      if (!reset) begin
         tmo_cnt_q <= '0;
      end else if ((state_q != WAIT) && (state_d == WAIT)) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == WAIT) && bus.bus_rdy_n) begin
         tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
   end

   // bus_err is high for the single cycle following the abort edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= timeout;
      end
   end

   assign bus.bus_err = bus_err_q;
`else
   assign bus.bus_err = 1'b0;
`endif

   // bus and core outputs decoded from the current state
   always_comb begin
      bus.bus_req_n   = 1'b1;
      bus.bus_as_n    = 1'b1;
      bus.bus_addr    = '0;
      bus.bus_rw      = 1'b0;
      bus.bus_wr_data = '0;
      bus.cpu_busy    = 1'b0;
      case (state_q)
         IDLE: begin
            bus.cpu_busy = bus.cpu_req & ~bus.flush;
         end
         REQ: begin
            bus.bus_req_n = 1'b0;
            bus.cpu_busy  = 1'b1;
         end
         ACCESS: begin
            bus.bus_req_n   = 1'b0;
            bus.bus_as_n    = 1'b0;
            bus.bus_addr    = addr_q;
            bus.bus_rw      = rw_q;
            bus.bus_wr_data = wr_data_q;
            bus.cpu_busy    = 1'b1;
         end
         WAIT: begin
            bus.bus_req_n   = 1'b0;
            bus.bus_addr    = addr_q;
            bus.bus_rw      = rw_q;
            bus.bus_wr_data = wr_data_q;
            bus.cpu_busy    = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.cpu_rd_data = rd_buf_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed testbench for bus_master_if. Inputs change 1ns after each rising
// edge and outputs are sampled there too, so every check sees settled values.
module tb_bus_master_if;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   bus_master_if_if #(.WORD_ADDR(30), .WORD_DATA(32)) bif ();

   bus_master_if dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset            = 1'b0;
      bif.cpu_req      = 1'b0;
      bif.cpu_rw       = 1'b0;
      bif.cpu_addr     = '0;
      bif.cpu_wr_data  = '0;
      bif.stall        = 1'b0;
      bif.flush        = 1'b0;
      bif.bus_grnt_n   = 1'b1;
      bif.bus_rd_data  = '0;
      bif.bus_rdy_n    = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({bif.bus_req_n, bif.bus_as_n, bif.cpu_busy, bif.bus_err} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_ctrl: got req_n/as_n/busy/err=%b expected 1100",
                  {bif.bus_req_n, bif.bus_as_n, bif.cpu_busy, bif.bus_err});
      end
      n_tests++;
      if ({bif.bus_addr, bif.bus_rw, bif.bus_wr_data, bif.cpu_rd_data} !== 95'd0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h rw=%b wd=%h rd=%h expected all 0",
                  bif.bus_addr, bif.bus_rw, bif.bus_wr_data, bif.cpu_rd_data);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_read_delayed_grant();
      int req_low;
      int as_low;
      req_low = 0;
      as_low  = 0;
      bif.bus_grnt_n  = 1'b1;
      bif.bus_rdy_n   = 1'b1;
      bif.bus_rd_data = 32'hDEAD_BEEF;
      bif.cpu_req     = 1'b1;
      bif.cpu_rw      = 1'b1;
      bif.cpu_addr    = 30'h3F00_0000;
      bif.cpu_wr_data = 32'hFFFF_0000;
      tick();
      bif.cpu_req = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (bif.bus_req_n === 1'b0) req_low++;
         if (bif.bus_as_n === 1'b0) begin
            as_low++;
            n_tests++;
            if ({bif.bus_rw, bif.bus_addr} !== {1'b1, 30'h3F00_0000}) begin
               n_fail++;
               $display("FAIL read_strobe: got rw=%b addr=%h expected rw=1 addr=3f000000",
                        bif.bus_rw, bif.bus_addr);
            end
         end
         if (c == 4) bif.bus_grnt_n = 1'b0;
         if (c == 6) begin
            bif.bus_rdy_n   = 1'b0;
            bif.bus_rd_data = 32'h0000_5678;
         end
         tick();
      end
      if (bif.bus_req_n === 1'b0) req_low++;
      n_tests++;
      if (req_low !== 6) begin
         n_fail++;
         $display("FAIL read_req_len: got %0d cycles of bus_req_n low expected 6", req_low);
      end
      n_tests++;
      if (as_low !== 1) begin
         n_fail++;
         $display("FAIL read_as_len: got %0d strobe cycles expected 1", as_low);
      end
      n_tests++;
      if ({bif.cpu_busy, bif.cpu_rd_data} !== {1'b0, 32'h0000_5678}) begin
         n_fail++;
         $display("FAIL read_done: got busy=%b rd=%h expected busy=0 rd=00005678",
                  bif.cpu_busy, bif.cpu_rd_data);
      end
      bif.bus_rdy_n = 1'b1;
      tick();
   endtask

   task automatic test_write();
      bif.bus_grnt_n  = 1'b0;
      bif.bus_rdy_n   = 1'b1;
      bif.bus_rd_data = 32'h9999_9999;
      bif.cpu_req     = 1'b1;
      bif.cpu_rw      = 1'b0;
      bif.cpu_addr    = 30'h1000_0000;
      bif.cpu_wr_data = 32'h0000_1234;
      #1;
      n_tests++;
      if (bif.cpu_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL write_busy_idle: got %b expected 1", bif.cpu_busy);
      end
      tick();
      bif.cpu_req = 1'b0;
      n_tests++;
      if ({bif.bus_req_n, bif.bus_as_n, bif.bus_addr} !== {2'b01, 30'h0}) begin
         n_fail++;
         $display("FAIL write_req: got req_n=%b as_n=%b addr=%h expected 0 1 0",
                  bif.bus_req_n, bif.bus_as_n, bif.bus_addr);
      end
      tick();
      n_tests++;
      if ({bif.bus_as_n, bif.bus_rw, bif.bus_addr, bif.bus_wr_data} !==
          {2'b00, 30'h1000_0000, 32'h0000_1234}) begin
         n_fail++;
         $display("FAIL write_access: got as_n=%b rw=%b addr=%h wd=%h expected 0 0 10000000 00001234",
                  bif.bus_as_n, bif.bus_rw, bif.bus_addr, bif.bus_wr_data);
      end
      bif.bus_grnt_n = 1'b1;
      tick();
      n_tests++;
      if ({bif.bus_req_n, bif.bus_as_n, bif.bus_addr, bif.bus_wr_data} !==
          {2'b01, 30'h1000_0000, 32'h0000_1234}) begin
         n_fail++;
         $display("FAIL write_wait: got req_n=%b as_n=%b addr=%h wd=%h expected 0 1 10000000 00001234",
                  bif.bus_req_n, bif.bus_as_n, bif.bus_addr, bif.bus_wr_data);
      end
      bif.bus_rdy_n = 1'b0;
      tick();
      n_tests++;
      if ({bif.cpu_busy, bif.bus_req_n, bif.bus_addr, bif.bus_wr_data, bif.cpu_rd_data} !==
          {2'b01, 30'h0, 32'h0, 32'h0000_5678}) begin
         n_fail++;
         $display("FAIL write_done: got busy=%b req_n=%b addr=%h wd=%h rd=%h expected 0 1 0 0 00005678",
                  bif.cpu_busy, bif.bus_req_n, bif.bus_addr, bif.bus_wr_data, bif.cpu_rd_data);
      end
      bif.bus_rdy_n  = 1'b1;
      bif.bus_grnt_n = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      bif.bus_grnt_n  = 1'b0;
      bif.bus_rdy_n   = 1'b1;
      bif.bus_rd_data = 32'hA5A5_0001;
      bif.stall       = 1'b1;
      bif.cpu_req     = 1'b1;
      bif.cpu_rw      = 1'b1;
      bif.cpu_addr    = 30'h0000_0100;
      tick();
      tick();
      bif.bus_rdy_n = 1'b0;
      tick();
      bif.bus_rdy_n   = 1'b1;
      bif.bus_rd_data = 32'h1111_1111;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if ({bif.cpu_busy, bif.bus_req_n, bif.cpu_rd_data} !== {2'b01, 32'hA5A5_0001}) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got busy=%b req_n=%b rd=%h expected 0 1 a5a50001",
                     k, bif.cpu_busy, bif.bus_req_n, bif.cpu_rd_data);
         end
         if (k == 3) bif.stall = 1'b0;
         tick();
      end
      n_tests++;
      if ({bif.cpu_busy, bif.bus_req_n} !== 2'b11) begin
         n_fail++;
         $display("FAIL stall_release: got busy=%b req_n=%b expected 1 1 (back in IDLE)",
                  bif.cpu_busy, bif.bus_req_n);
      end
      bif.cpu_req = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      bif.bus_grnt_n  = 1'b0;
      bif.bus_rdy_n   = 1'b1;
      bif.cpu_req     = 1'b1;
      bif.flush       = 1'b1;
      bif.cpu_rw      = 1'b0;
      bif.cpu_addr    = 30'h0000_0055;
      bif.cpu_wr_data = 32'h0000_CAFE;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if ({bif.bus_req_n, bif.cpu_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_idle%0d: got req_n=%b busy=%b expected 1 0",
                     i, bif.bus_req_n, bif.cpu_busy);
         end
      end
      bif.flush = 1'b0;
      tick();
      bif.cpu_req = 1'b0;
      tick();
      tick();
      bif.flush   = 1'b1;
      bif.cpu_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if ({bif.bus_req_n, bif.bus_as_n, bif.cpu_busy, bif.bus_addr} !== {3'b011, 30'h55}) begin
            n_fail++;
            $display("FAIL flush_wait%0d: got req_n=%b as_n=%b busy=%b addr=%h expected 0 1 1 55",
                     i, bif.bus_req_n, bif.bus_as_n, bif.cpu_busy, bif.bus_addr);
         end
         tick();
      end
      bif.bus_rdy_n = 1'b0;
      tick();
      n_tests++;
      if ({bif.bus_req_n, bif.cpu_busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL flush_done: got req_n=%b busy=%b expected 1 0",
                  bif.bus_req_n, bif.cpu_busy);
      end
      bif.cpu_req   = 1'b0;
      bif.flush     = 1'b0;
      bif.bus_rdy_n = 1'b1;
      tick();
   endtask

   task automatic test_timeout();
      bif.bus_grnt_n  = 1'b0;
      bif.bus_rdy_n   = 1'b1;
      bif.bus_rd_data = 32'h7777_7777;
      bif.cpu_req     = 1'b1;
      bif.cpu_rw      = 1'b1;
      bif.cpu_addr    = 30'h0000_002A;
      tick();
      bif.cpu_req = 1'b0;
      tick();
      tick();
`ifdef BUS_MASTER_IF_TIMEOUT_EN
      begin
         int n_wait;
         int err_seen;
         n_wait   = 0;
         err_seen = 0;
         while ((bif.bus_req_n === 1'b0) && (n_wait < 400)) begin
            n_wait++;
            if (bif.bus_err !== 1'b0) err_seen++;
            tick();
         end
         n_tests++;
         if (n_wait !== 256) begin
            n_fail++;
            $display("FAIL tmo_len: got %0d WAIT cycles expected 256", n_wait);
         end
         n_tests++;
         if (err_seen !== 0) begin
            n_fail++;
            $display("FAIL tmo_early_err: got %0d err cycles in WAIT expected 0", err_seen);
         end
         n_tests++;
         if ({bif.bus_err, bif.cpu_busy, bif.cpu_rd_data} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL tmo_done: got err=%b busy=%b rd=%h expected 1 0 0",
                     bif.bus_err, bif.cpu_busy, bif.cpu_rd_data);
         end
         tick();
         n_tests++;
         if (bif.bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_pulse: got err=%b one cycle later expected 0", bif.bus_err);
         end
      end
`else
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 1000; i++) begin
            if ((bif.bus_req_n !== 1'b0) || (bif.bus_as_n !== 1'b1) || (bif.bus_err !== 1'b0)) bad++;
            tick();
         end
         n_tests++;
         if (bad !== 0) begin
            n_fail++;
            $display("FAIL wait_forever: got %0d non-WAIT cycles in 1000 expected 0", bad);
         end
         n_tests++;
         if ({bif.cpu_busy, bif.bus_addr, bif.bus_err} !== {1'b1, 30'h2A, 1'b0}) begin
            n_fail++;
            $display("FAIL wait_forever_state: got busy=%b addr=%h err=%b expected 1 2a 0",
                     bif.cpu_busy, bif.bus_addr, bif.bus_err);
         end
         bif.bus_rdy_n   = 1'b0;
         bif.bus_rd_data = 32'h0BAD_F00D;
         tick();
         n_tests++;
         if (bif.cpu_rd_data !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL wait_late_rdy: got rd=%h expected 0badf00d", bif.cpu_rd_data);
         end
      end
`endif
      bif.bus_rdy_n = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      bif.bus_grnt_n  = 1'b0;
      bif.bus_rdy_n   = 1'b1;
      bif.bus_rd_data = 32'hFEED_0042;
      bif.cpu_req     = 1'b1;
      bif.cpu_rw      = 1'b1;
      bif.cpu_addr    = 30'h0000_0003;
      tick();
      bif.cpu_req = 1'b0;
      tick();
      bif.bus_rdy_n = 1'b0;
      tick();
      n_tests++;
      if (bif.cpu_rd_data !== 32'hFEED_0042) begin
         n_fail++;
         $display("FAIL rstmid_prep: got rd=%h expected feed0042", bif.cpu_rd_data);
      end
      bif.bus_rdy_n = 1'b1;
      tick();
      bif.cpu_req = 1'b1;
      tick();
      bif.cpu_req = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({bif.bus_req_n, bif.bus_as_n, bif.bus_addr} !== {2'b01, 30'h3}) begin
         n_fail++;
         $display("FAIL rstmid_wait: got req_n=%b as_n=%b addr=%h expected 0 1 3",
                  bif.bus_req_n, bif.bus_as_n, bif.bus_addr);
      end
      reset = 1'b0;
      tick();
      n_tests++;
      if ({bif.bus_req_n, bif.bus_as_n, bif.cpu_busy, bif.bus_err, bif.bus_addr, bif.cpu_rd_data} !==
          {4'b1100, 30'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL rstmid_idle: got req_n=%b as_n=%b busy=%b err=%b addr=%h rd=%h expected 1 1 0 0 0 0",
                  bif.bus_req_n, bif.bus_as_n, bif.cpu_busy, bif.bus_err, bif.bus_addr, bif.cpu_rd_data);
      end
      reset         = 1'b1;
      bif.bus_rdy_n = 1'b0;
      tick();
      n_tests++;
      if ({bif.bus_req_n, bif.bus_as_n, bif.cpu_rd_data} !== {2'b11, 32'h0}) begin
         n_fail++;
         $display("FAIL rstmid_after: got req_n=%b as_n=%b rd=%h expected 1 1 0",
                  bif.bus_req_n, bif.bus_as_n, bif.cpu_rd_data);
      end
      bif.bus_rdy_n = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_read_delayed_grant();
      test_write();
      test_stall();
      test_flush();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
